ball_collision_mux: RTL

//  Consumer end of the per-pixel bitmap interface: takes drawingRequest/RGBout

---
 rtl/ball_collision_mux.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ball_collision_mux.sv
// Final pixel colour mux plus per-frame collision accumulation.
// Overlaps are gathered across a frame and reported as one-cycle pulses after the next frame start.
module ball_collision_mux #(
  parameter int unsigned NUM_BALLS = 4,
  parameter logic [7:0]  BG_RGB    = 8'h00
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [NUM_BALLS-1:0]     ballDR,
  input  logic [NUM_BALLS*8-1:0]   ballRGB,
  input  logic                     ropeDR,
  input  logic [7:0]               ropeRGB,
  input  logic                     playerDR,
  input  logic [7:0]               playerRGB,
  input  logic                     wallDR,
  input  logic [7:0]               wallRGB,
  output logic [7:0]               RGBout,
  output logic [NUM_BALLS-1:0]     ballHitRope,
  output logic [NUM_BALLS-1:0]     ballHitWall,
  output logic                     playerHit
);

  typedef enum logic [1:0] {WAIT_SOF, COLLECT, REPORT} state_t;

  state_t               state, state_nxt;
  logic [NUM_BALLS-1:0] rope_ov, wall_ov;
  logic                 player_ov;
  logic [NUM_BALLS-1:0] rope_f, rope_f_nxt, wall_f, wall_f_nxt;
  logic                 player_f, player_f_nxt;
  logic                 boundary;
  logic [NUM_BALLS-1:0] rope_pick;
  logic [7:0]           rgb_nxt;
  logic                 ball_found;

  assign rope_ov   = ballDR & {NUM_BALLS{ropeDR}};
  assign wall_ov   = ballDR & {NUM_BALLS{wallDR}};
  assign player_ov = playerDR & (|ballDR);

  always_comb begin
    rgb_nxt    = BG_RGB;
    ball_found = 1'b0;
    if (ropeDR) begin
      rgb_nxt = ropeRGB;
    end else if (playerDR) begin
      rgb_nxt = playerRGB;
    end else begin
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
        if (ballDR[i] && !ball_found) begin
          rgb_nxt    = ballRGB[8*i +: 8];
          ball_found = 1'b1;
        end
      end
      if (!ball_found && wallDR)
        rgb_nxt = wallRGB;
    end
  end

  // The rope pops only the lowest-indexed ball that touched it this frame.
  always_comb begin
    rope_pick = '0;
    for (int unsigned i = 0; i < NUM_BALLS; i++) begin
      if (rope_f[i] && (rope_pick == '0))
        rope_pick[i] = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    rope_f_nxt   = rope_f;
    wall_f_nxt   = wall_f;
    player_f_nxt = player_f;
    boundary     = 1'b0;
    case (state)
      WAIT_SOF: begin
        rope_f_nxt   = '0;
        wall_f_nxt   = '0;
        player_f_nxt = 1'b0;
        if (startOfFrame) begin
          state_nxt    = COLLECT;
          rope_f_nxt   = rope_ov;
          wall_f_nxt   = wall_ov;
          player_f_nxt = player_ov;
        end
      end
      COLLECT: begin
        if (startOfFrame) begin
          // Reload with the SOF pixel's overlaps so they belong to the new frame.
          boundary     = 1'b1;
          state_nxt    = REPORT;
          rope_f_nxt   = rope_ov;
          wall_f_nxt   = wall_ov;
          player_f_nxt = player_ov;
        end else begin
          rope_f_nxt   = rope_f | rope_ov;
          wall_f_nxt   = wall_f | wall_ov;
          player_f_nxt = player_f | player_ov;
        end
      end
      REPORT: begin
        state_nxt    = COLLECT;
        rope_f_nxt   = rope_f | rope_ov;
        wall_f_nxt   = wall_f | wall_ov;
        player_f_nxt = player_f | player_ov;
      end
      default: begin
        state_nxt    = WAIT_SOF;
        rope_f_nxt   = '0;
        wall_f_nxt   = '0;
        player_f_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= WAIT_SOF;
      rope_f      <= '0;
      wall_f      <= '0;
      player_f    <= 1'b0;
      RGBout      <= 8'h00;
      ballHitRope <= '0;
      ballHitWall <= '0;
      playerHit   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rope_f   <= rope_f_nxt;
      wall_f   <= wall_f_nxt;
      player_f <= player_f_nxt;
      RGBout   <= rgb_nxt;
      if (boundary) begin
        ballHitRope <= rope_pick;
        ballHitWall <= wall_f;
        playerHit   <= player_f & ~(|rope_f);
      end else begin
        ballHitRope <= '0;
        ballHitWall <= '0;
        playerHit   <= 1'b0;
      end
    end
  end

endmodule
